// File: rtl/dma_read_controller.sv
// Frame-read DMA: loads frame base addresses from the CPU FIFO and issues one frame of DDR burst reads per frame start.
// Define DMA_RD_FRAME_COUNT_EN to add the frame_count_o completed-frame counter.
module dma_read_controller #(
  parameter int unsigned FRAME_BURSTS = 8100,
  parameter int unsigned BURST_BYTES  = 256,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        sys_clk_i,
  input  logic        rstn_i,
  input  logic        fifo_empty_i,
  input  logic [31:0] fifo_data_i,
  input  logic        fifo_data_valid_i,
  output logic        fifo_rd_o,
  input  logic        frame_start_i,
  input  logic        rd_buf_afull_i,
  output logic        ddr_rd_req_o,
  input  logic        ddr_rd_ack_i,
  output logic [31:0] ddr_rd_addr_o,
  output logic        frame_end_interrupt_o,
  output logic        underrun_o,
  output logic        buf_release_wr_o,
  output logic [31:0] buf_release_addr_o,
  output logic        dma_busy_o
`ifdef DMA_RD_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_FS,
    S_REQ,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(FRAME_BURSTS - 1);
  localparam logic [31:0]      BURST_INC  = 32'(BURST_BYTES);

  state_t           state, state_nxt;
  logic             have_buf, have_buf_nxt;
  logic [31:0]      cur_base, cur_base_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             fs_pend, fs_pend_nxt;
  logic             fifo_rd_nxt;
  logic             req_nxt;
  logic [31:0]      addr_nxt;
  logic             rel_wr_nxt;
  logic [31:0]      rel_addr_nxt;
  logic             underrun_nxt;
  logic             irq_trig;
  logic [3:0]       irq_dly;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no inferred latch).
    state_nxt     = state;
    have_buf_nxt  = have_buf;
    cur_base_nxt  = cur_base;
    burst_cnt_nxt = burst_cnt;
    fs_pend_nxt   = fs_pend;
    fifo_rd_nxt   = 1'b0;
    req_nxt       = ddr_rd_req_o;
    addr_nxt      = ddr_rd_addr_o;
    rel_wr_nxt    = 1'b0;
    rel_addr_nxt  = buf_release_addr_o;
    underrun_nxt  = 1'b0;
    irq_trig      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!fifo_empty_i) begin
          fifo_rd_nxt = 1'b1;
          state_nxt   = S_LOAD;
        end
      end

      S_LOAD: begin
        if (frame_start_i) fs_pend_nxt = 1'b1;
        if (fifo_data_valid_i) begin
          // The buffer being replaced goes back to the CPU.
          if (have_buf) begin
            rel_wr_nxt   = 1'b1;
            rel_addr_nxt = cur_base;
          end
          cur_base_nxt = fifo_data_i;
          have_buf_nxt = 1'b1;
          state_nxt    = S_WAIT_FS;
        end
      end

      S_WAIT_FS: begin
        if (frame_start_i || fs_pend) begin
          fs_pend_nxt   = 1'b0;
          addr_nxt      = cur_base;
          burst_cnt_nxt = '0;
          req_nxt       = !rd_buf_afull_i;
          state_nxt     = S_REQ;
        end else if (!fifo_empty_i) begin
          fifo_rd_nxt = 1'b1;
          state_nxt   = S_LOAD;
        end
      end

      S_REQ: begin
        if (frame_start_i) begin
          // Underrun: drop the request (a coincident ack is discarded) and restart the frame.
          req_nxt       = 1'b0;
          underrun_nxt  = 1'b1;
          addr_nxt      = cur_base;
          burst_cnt_nxt = '0;
        end else if (ddr_rd_req_o && ddr_rd_ack_i) begin
          addr_nxt      = ddr_rd_addr_o + BURST_INC;
          burst_cnt_nxt = burst_cnt + 1'b1;
          if (burst_cnt == LAST_BURST) begin
            req_nxt   = 1'b0;
            irq_trig  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            req_nxt = !rd_buf_afull_i;
          end
        end else if (!ddr_rd_req_o) begin
          // An outstanding request is held; only an idle one looks at back-pressure.
          req_nxt = !rd_buf_afull_i;
        end
      end

      S_DONE: begin
        if (frame_start_i) fs_pend_nxt = 1'b1;
        state_nxt = S_WAIT_FS;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state              <= S_IDLE;
      have_buf           <= 1'b0;
      cur_base           <= '0;
      burst_cnt          <= '0;
      fs_pend            <= 1'b0;
      fifo_rd_o          <= 1'b0;
      ddr_rd_req_o       <= 1'b0;
      ddr_rd_addr_o      <= '0;
      buf_release_wr_o   <= 1'b0;
      buf_release_addr_o <= '0;
      underrun_o         <= 1'b0;
      irq_dly            <= '0;
    end else begin
      state              <= state_nxt;
      have_buf           <= have_buf_nxt;
      cur_base           <= cur_base_nxt;
      burst_cnt          <= burst_cnt_nxt;
      fs_pend            <= fs_pend_nxt;
      fifo_rd_o          <= fifo_rd_nxt;
      ddr_rd_req_o       <= req_nxt;
      ddr_rd_addr_o      <= addr_nxt;
      buf_release_wr_o   <= rel_wr_nxt;
      buf_release_addr_o <= rel_addr_nxt;
      underrun_o         <= underrun_nxt;
      irq_dly            <= {irq_dly[2:0], irq_trig};
    end
  end

`ifdef DMA_RD_FRAME_COUNT_EN
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i)       frame_count_o <= '0;
    else if (irq_trig) frame_count_o <= frame_count_o + 16'd1;
  end
`endif

  // Four-cycle interrupt stretched from the single-cycle completion trigger.
  assign frame_end_interrupt_o = |irq_dly;
  assign dma_busy_o            = (state == S_REQ);

endmodule

// File: tb/tb_dma_read_controller.sv
// Self-checking bench for dma_read_controller: directed frames plus randomized ack/back-pressure/buffer traffic,
// checked against a transaction-level model (expected burst addresses, released buffers, completed frames).
module tb_dma_read_controller;

  localparam int FB = 4;
  localparam int BB = 256;

  logic        sys_clk_i = 1'b0;
  logic        rstn_i;
  logic        fifo_empty_i;
  logic [31:0] fifo_data_i;
  logic        fifo_data_valid_i;
  logic        fifo_rd_o;
  logic        frame_start_i;
  logic        rd_buf_afull_i;
  logic        ddr_rd_req_o;
  logic        ddr_rd_ack_i;
  logic [31:0] ddr_rd_addr_o;
  logic        frame_end_interrupt_o;
  logic        underrun_o;
  logic        buf_release_wr_o;
  logic [31:0] buf_release_addr_o;
  logic        dma_busy_o;
`ifdef DMA_RD_FRAME_COUNT_EN
  logic [15:0] frame_count_o;
`endif

  always #5 sys_clk_i = ~sys_clk_i;

  dma_read_controller #(
    .FRAME_BURSTS(FB),
    .BURST_BYTES (BB),
    .CNT_W       (16)
  ) dut (
    .sys_clk_i            (sys_clk_i),
    .rstn_i               (rstn_i),
    .fifo_empty_i         (fifo_empty_i),
    .fifo_data_i          (fifo_data_i),
    .fifo_data_valid_i    (fifo_data_valid_i),
    .fifo_rd_o            (fifo_rd_o),
    .frame_start_i        (frame_start_i),
    .rd_buf_afull_i       (rd_buf_afull_i),
    .ddr_rd_req_o         (ddr_rd_req_o),
    .ddr_rd_ack_i         (ddr_rd_ack_i),
    .ddr_rd_addr_o        (ddr_rd_addr_o),
    .frame_end_interrupt_o(frame_end_interrupt_o),
    .underrun_o           (underrun_o),
    .buf_release_wr_o     (buf_release_wr_o),
    .buf_release_addr_o   (buf_release_addr_o),
    .dma_busy_o           (dma_busy_o)
`ifdef DMA_RD_FRAME_COUNT_EN
    ,
    .frame_count_o        (frame_count_o)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Environment state: CPU FIFO, ack generator, monitor records.
  logic [31:0] fifo_q[$];
  bit          rd_seen;
  logic [31:0] rd_data;
  int          ack_mode;   // 0: ack tied high, 1: random, 2: ack after request held 3 cycles
  bit          afull_rand;
  int          req_age;
  bit          prev_acc;
  logic [31:0] acc_q[$];
  int          acc_cyc_q[$];
  logic [31:0] rel_q[$];
  int          irq_q[$];
  int          irq_gap_q[$];
  int          irq_run;
  int          underrun_cnt;
  int          fifo_rd_cnt;
  int          cyc;
  int          last_acc_cyc;
  int          stab_err;
  bit          prev_req, prev_ack, prev_fs;
  logic [31:0] prev_addr;

  // Reference model: current base, buffers owed back to the CPU, completed frames.
  logic [31:0] m_base;
  bit          m_have;
  logic [31:0] m_rel[$];
  int          m_frames;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Finish the current cycle (monitor at negedge), then set up inputs for the next one.
  task automatic tick();
    @(negedge sys_clk_i);
    cyc++;
    if (rstn_i && prev_req && !prev_ack && !prev_fs &&
        !(ddr_rd_req_o && ddr_rd_addr_o == prev_addr)) stab_err++;
    prev_acc = rstn_i && ddr_rd_req_o && ddr_rd_ack_i && !frame_start_i;
    if (prev_acc) begin
      acc_q.push_back(ddr_rd_addr_o);
      acc_cyc_q.push_back(cyc);
      last_acc_cyc = cyc;
    end
    if (buf_release_wr_o) rel_q.push_back(buf_release_addr_o);
    if (underrun_o) underrun_cnt++;
    if (fifo_rd_o) fifo_rd_cnt++;
    if (frame_end_interrupt_o) begin
      if (irq_run == 0) irq_gap_q.push_back(cyc - last_acc_cyc);
      irq_run++;
    end else if (irq_run > 0) begin
      irq_q.push_back(irq_run);
      irq_run = 0;
    end
    prev_req  = ddr_rd_req_o;
    prev_ack  = ddr_rd_ack_i;
    prev_fs   = frame_start_i;
    prev_addr = ddr_rd_addr_o;

    @(posedge sys_clk_i);
    #1;
    frame_start_i     = 1'b0;
    fifo_data_valid_i = 1'b0;
    if (rd_seen) begin
      fifo_data_valid_i = 1'b1;
      fifo_data_i       = rd_data;
      rd_seen           = 1'b0;
    end
    if (fifo_rd_o && fifo_q.size() > 0) begin
      rd_data = fifo_q.pop_front();
      rd_seen = 1'b1;
    end
    fifo_empty_i = (fifo_q.size() == 0);
    if (afull_rand) rd_buf_afull_i = ($urandom_range(3) == 0);
    if (ddr_rd_req_o) req_age = prev_acc ? 1 : req_age + 1;
    else              req_age = 0;
    case (ack_mode)
      0:       ddr_rd_ack_i = 1'b1;
      1:       ddr_rd_ack_i = 1'($urandom_range(1));
      default: ddr_rd_ack_i = (req_age > 3);
    endcase
  endtask

  task automatic post(input logic [31:0] a);
    fifo_q.push_back(a);
    fifo_empty_i = 1'b0;
    if (m_have) m_rel.push_back(m_base);
    m_base = a;
    m_have = 1'b1;
  endtask

  task automatic check_releases(input string tag);
    check($sformatf("%s release count", tag), 32'(rel_q.size()), 32'(m_rel.size()));
    for (int i = 0; i < m_rel.size(); i++)
      check($sformatf("%s release[%0d]", tag, i), (i < rel_q.size()) ? rel_q[i] : 32'hDEAD_BEEF, m_rel[i]);
    rel_q.delete();
    m_rel.delete();
  endtask

  task automatic check_frame_count(input string tag);
`ifdef DMA_RD_FRAME_COUNT_EN
    check($sformatf("%s frame_count", tag), {16'b0, frame_count_o}, 32'(m_frames & 16'hFFFF));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic run_frame(input string tag, input bit hold, input bit consec);
    bit held = 1'b0;
    acc_q.delete();
    acc_cyc_q.delete();
    irq_q.delete();
    irq_gap_q.delete();
    frame_start_i = 1'b1;
    tick();
    check($sformatf("%s busy at start", tag), {31'b0, dma_busy_o}, 32'd1);
    for (int i = 0; i < 600 && irq_q.size() == 0; i++) begin
      if (hold && !held && acc_q.size() >= 1) begin
        rd_buf_afull_i = 1'b1;
        repeat (10) tick();
        rd_buf_afull_i = 1'b0;
        held = 1'b1;
      end
      tick();
    end
    m_frames++;
    check($sformatf("%s interrupt count", tag), 32'(irq_q.size()), 32'd1);
    check($sformatf("%s interrupt length", tag), (irq_q.size() > 0) ? 32'(irq_q[0]) : 32'd0, 32'd4);
    check($sformatf("%s interrupt delay", tag), (irq_gap_q.size() > 0) ? 32'(irq_gap_q[0]) : 32'd0, 32'd1);
    check($sformatf("%s burst count", tag), 32'(acc_q.size()), 32'(FB));
    for (int i = 0; i < FB; i++)
      check($sformatf("%s burst[%0d] addr", tag, i), (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_BEEF,
            m_base + 32'(i * BB));
    if (consec)
      check($sformatf("%s back-to-back", tag),
            (acc_cyc_q.size() == FB) ? 32'(acc_cyc_q[FB-1] - acc_cyc_q[0]) : 32'd0, 32'(FB - 1));
    check($sformatf("%s busy after", tag), {31'b0, dma_busy_o}, 32'd0);
    check_frame_count(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_posts;
    int fr_cnt;
    rstn_i = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_data_i = '0;
    fifo_data_valid_i = 1'b0;
    frame_start_i = 1'b0;
    rd_buf_afull_i = 1'b0;
    ddr_rd_ack_i = 1'b0;
    ack_mode = 0;
    afull_rand = 1'b0;
    m_have = 1'b0;
    m_base = '0;
    m_frames = 0;

    // Reset values
    repeat (3) tick();
    check("reset strobes", {26'b0, fifo_rd_o, ddr_rd_req_o, frame_end_interrupt_o, underrun_o,
                            buf_release_wr_o, dma_busy_o}, 32'd0);
    check("reset rd addr", ddr_rd_addr_o, 32'd0);
    check("reset release addr", buf_release_addr_o, 32'd0);
    check_frame_count("reset");
    rstn_i = 1'b1;
    repeat (2) tick();

    // Frame start with no buffer is ignored
    frame_start_i = 1'b1;
    repeat (4) tick();
    check("idle frame start ignored", 32'(acc_q.size()) | {31'b0, dma_busy_o}, 32'd0);

    // First buffer: loaded, no release, no frame until frame start
    post(32'h1000_0000);
    repeat (8) tick();
    check("first load fifo reads", 32'(fifo_rd_cnt), 32'd1);
    check("no auto start after load", 32'(acc_q.size()), 32'd0);
    check_releases("first load");
    run_frame("frame1", 1'b0, 1'b1);

    // Empty FIFO: same buffer repeated, no FIFO read
    fr_cnt = fifo_rd_cnt;
    run_frame("frame2 repeat", 1'b0, 1'b1);
    check("frame2 no fifo read", 32'(fifo_rd_cnt - fr_cnt), 32'd0);

    // Two posts between frames: latest wins, both superseded buffers released
    post(32'h2000_0000);
    post(32'h3000_0000);
    repeat (12) tick();
    check_releases("skip");
    run_frame("frame3 latest", 1'b0, 1'b1);

    // Back-pressure mid-frame with slow acks
    ack_mode = 2;
    stab_err = 0;
    run_frame("frame4 afull", 1'b1, 1'b0);
    check("req/addr stable until ack", 32'(stab_err), 32'd0);

    // 32-bit address wrap
    ack_mode = 0;
    post(32'hFFFF_FE00);
    repeat (8) tick();
    check_releases("wrap load");
    run_frame("frame5 wrap", 1'b0, 1'b1);

    // Underrun after two acks
    acc_q.delete();
    irq_q.delete();
    underrun_cnt = 0;
    frame_start_i = 1'b1;
    for (int i = 0; i < 50 && acc_q.size() < 2; i++) tick();
    check("underrun acks before abort", 32'(acc_q.size()), 32'd2);
    frame_start_i = 1'b1;
    tick();
    tick();
    check("underrun pulse", 32'(underrun_cnt), 32'd1);
    check("underrun no interrupt", 32'(irq_q.size() + irq_run), 32'd0);
    check_frame_count("underrun abort");
    for (int i = 0; i < 100 && irq_q.size() == 0; i++) tick();
    m_frames++;
    check("underrun restart bursts", 32'(acc_q.size()), 32'(2 + FB));
    for (int i = 0; i < FB; i++)
      check($sformatf("underrun restart burst[%0d]", i), (i + 2 < acc_q.size()) ? acc_q[i+2] : 32'hDEAD_BEEF,
            m_base + 32'(i * BB));
    check("underrun single pulse", 32'(underrun_cnt), 32'd1);
    check("underrun restart interrupt", 32'(irq_q.size()), 32'd1);
    check_frame_count("underrun restart");

    // Randomized frames: random buffers, acks and back-pressure
    stab_err = 0;
    for (int f = 0; f < 6; f++) begin
      n_posts = $urandom_range(2);
      for (int p = 0; p < n_posts; p++) post($urandom & 32'hFFFF_FF00);
      repeat (12) tick();
      check_releases($sformatf("rand%0d", f));
      ack_mode = 1;
      afull_rand = 1'b1;
      run_frame($sformatf("rand%0d", f), 1'b0, 1'b0);
      afull_rand = 1'b0;
      rd_buf_afull_i = 1'b0;
      ack_mode = 0;
      repeat ($urandom_range(3)) tick();
    end
    check("random req/addr stable until ack", 32'(stab_err), 32'd0);

    // Reset mid-frame
    ack_mode = 2;
    acc_q.delete();
    irq_q.delete();
    rel_q.delete();
    frame_start_i = 1'b1;
    for (int i = 0; i < 50 && acc_q.size() < 1; i++) tick();
    check("reset test busy before", {31'b0, dma_busy_o}, 32'd1);
    rstn_i = 1'b0;
    rd_seen = 1'b0;
    tick();
    check("mid-frame reset strobes", {26'b0, fifo_rd_o, ddr_rd_req_o, frame_end_interrupt_o, underrun_o,
                                      buf_release_wr_o, dma_busy_o}, 32'd0);
    check("mid-frame reset addr", ddr_rd_addr_o, 32'd0);
    m_have = 1'b0;
    m_frames = 0;
    check_frame_count("mid-frame reset");
    tick();
    rstn_i = 1'b1;
    fr_cnt = fifo_rd_cnt;
    frame_start_i = 1'b1;
    repeat (6) tick();
    check("post-reset idle no bursts", 32'(acc_q.size()), 32'd1);
    check("post-reset idle no fifo read", 32'(fifo_rd_cnt - fr_cnt), 32'd0);
    check("post-reset no interrupt", 32'(irq_q.size() + irq_run), 32'd0);
    ack_mode = 0;
    post(32'h4000_0000);
    repeat (8) tick();
    check_releases("post-reset load");
    run_frame("post-reset frame", 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
